// File: rtl/life_ctrl_fsm_if.sv
// Control/datapath bundle for the Game-of-Life successor controller.
// The master side is the controller; the slave side is switches plus datapath.
interface life_ctrl_fsm_if #(
  parameter int COORD_W = 8,
  parameter int GEN_W   = 16
);
  logic               set;
  logic               go;
  logic               stop;
  logic               step;
  logic [COORD_W-1:0] load_val;
  logic               draw_done;
  logic               gen_done;
  logic [COORD_W-1:0] x_out;
  logic [COORD_W-1:0] y_out;
  logic               draw_cell;
  logic               start_gen;
  logic               running;
  logic               busy;
  logic [GEN_W-1:0]   gen_count;

  modport master (
    input  set, go, stop, step, load_val, draw_done, gen_done,
    output x_out, y_out, draw_cell, start_gen, running, busy, gen_count
  );

  modport slave (
    output set, go, stop, step, load_val, draw_done, gen_done,
    input  x_out, y_out, draw_cell, start_gen, running, busy, gen_count
  );
endinterface

// File: rtl/life_ctrl_fsm.sv
// Successor control FSM: cell entry and draw, free-running or single-step generations.
// Pulses are single-cycle; datapath completion is a level or pulse handshake.
module life_ctrl_fsm #(
  parameter int COORD_W  = 8,
  parameter int TICK_DIV = 4,
  parameter int GEN_W    = 16
) (
  input logic            clock,
  input logic            reset,
  life_ctrl_fsm_if.master bus
);
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_X, X_WAIT, LOAD_Y, DRAW, DRAW_WAIT,
    READY, RUN_TICK, RUN_GEN, STEP_GEN
  } state_t;

  state_t             state, state_nxt;
  logic [TW-1:0]      tick_cnt;
  logic [COORD_W-1:0] x_q, y_q;
  logic [GEN_W-1:0]   gen_cnt;
  logic               stop_pend;
  logic               entry;
  logic               gen_accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      gen_cnt   <= '0;
      stop_pend <= 1'b0;
      entry     <= 1'b0;
    end else begin
      state <= state_nxt;
      entry <= (state_nxt != state);
      if (state == LOAD_X) x_q <= bus.load_val;
      if (state == LOAD_Y) y_q <= bus.load_val;
      if (gen_accept) gen_cnt <= gen_cnt + 1'b1;
      // Clears on entry, on expiry and on stop alike.
      if (state == RUN_TICK && state_nxt == RUN_TICK) tick_cnt <= tick_cnt + 1'b1;
      else tick_cnt <= '0;
      // A stop seen mid-generation is held until that generation completes.
      stop_pend <= (state == RUN_GEN) && (state_nxt == RUN_GEN) && (stop_pend || bus.stop);
    end
  end

  always_comb begin
    state_nxt  = state;
    gen_accept = 1'b0;
    case (state)
      IDLE:      if (bus.set) state_nxt = LOAD_X;
      LOAD_X:    if (!bus.set) state_nxt = X_WAIT;
      X_WAIT:    if (bus.set) state_nxt = LOAD_Y;
      LOAD_Y:    if (!bus.set) state_nxt = DRAW;
      DRAW:      state_nxt = DRAW_WAIT;
      DRAW_WAIT: if (bus.draw_done) state_nxt = READY;
      READY: begin
        if (bus.go)        state_nxt = RUN_TICK;
        else if (bus.step) state_nxt = STEP_GEN;
        else if (bus.set)  state_nxt = LOAD_X;
      end
      RUN_TICK: begin
        if (bus.stop)                   state_nxt = READY;
        else if (tick_cnt == TICK_LAST) state_nxt = RUN_GEN;
      end
      RUN_GEN: begin
        if (bus.gen_done) begin
          gen_accept = 1'b1;
          state_nxt  = (bus.stop || stop_pend) ? READY : RUN_TICK;
        end
      end
      STEP_GEN: begin
        if (bus.gen_done) begin
          gen_accept = 1'b1;
          state_nxt  = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.gen_count = gen_cnt;
  assign bus.draw_cell = (state == DRAW);
  assign bus.start_gen = entry && (state == RUN_GEN || state == STEP_GEN);
  assign bus.running   = (state == RUN_TICK) || (state == RUN_GEN);
  assign bus.busy      = (state == DRAW) || (state == RUN_GEN) || (state == STEP_GEN);
endmodule

// File: tb/tb_life_ctrl_fsm.sv
// Directed bench for life_ctrl_fsm with TICK_DIV=4, COORD_W=8, GEN_W=16.
module tb_life_ctrl_fsm;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sg_cyc = -100;

  life_ctrl_fsm_if #(.COORD_W(8), .GEN_W(16)) bus();

  life_ctrl_fsm #(.COORD_W(8), .TICK_DIV(4), .GEN_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.set = 0; bus.go = 0; bus.stop = 0; bus.step = 0;
    bus.load_val = 8'h00; bus.draw_done = 0; bus.gen_done = 0;
    repeat (2) tick();
    checks++; if (bus.x_out !== 8'h00) begin errors++; $display("FAIL reset_x_out: got %0h expected 0", bus.x_out); end
    checks++; if (bus.y_out !== 8'h00) begin errors++; $display("FAIL reset_y_out: got %0h expected 0", bus.y_out); end
    checks++; if ({bus.draw_cell, bus.start_gen, bus.running, bus.busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.draw_cell, bus.start_gen, bus.running, bus.busy}); end
    checks++; if (bus.gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen_count: got %0d expected 0", bus.gen_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cell_entry();
    int draws = 0;
    bus.set = 1; bus.load_val = 8'h12;
    repeat (3) tick();
    bus.set = 0;
    tick();
    bus.set = 1; bus.load_val = 8'h34;
    tick();
    bus.set = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.draw_cell) begin
        draws++;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL draw_busy: got %b expected 1", bus.busy); end
      end
    end
    checks++; if (draws != 1) begin errors++; $display("FAIL draw_pulse_count: got %0d expected 1", draws); end
    checks++; if (bus.x_out !== 8'h12) begin errors++; $display("FAIL cell_x_out: got %0h expected 12", bus.x_out); end
    checks++; if (bus.y_out !== 8'h34) begin errors++; $display("FAIL cell_y_out: got %0h expected 34", bus.y_out); end
    bus.draw_done = 1;
    tick();
    bus.draw_done = 0;
    checks++; if ({bus.busy, bus.running} !== 2'b00) begin errors++; $display("FAIL ready_after_draw: got %b expected 00", {bus.busy, bus.running}); end
  endtask

  task automatic test_free_run();
    int sg[$];
    int done_n = 0;
    int k = cyc;
    bus.go = 1;
    tick();
    bus.go = 0;
    for (int i = 0; i < 60 && done_n < 3; i++) begin
      tick();
      if (bus.start_gen) begin sg.push_back(cyc); sg_cyc = cyc; end
      bus.gen_done = (cyc == sg_cyc + 2);
      if (bus.gen_done) done_n++;
    end
    tick();
    bus.gen_done = 0;
    checks++; if (done_n != 3 || sg.size() != 3) begin
      errors++; $display("FAIL free_run_pulses: got %0d starts %0d dones expected 3 and 3", sg.size(), done_n);
    end else begin
      checks++; if (sg[0] - k != 5) begin errors++; $display("FAIL first_start_delay: got %0d expected 5", sg[0] - k); end
      checks++; if (sg[1] - sg[0] != 7) begin errors++; $display("FAIL start_spacing_1: got %0d expected 7", sg[1] - sg[0]); end
      checks++; if (sg[2] - sg[1] != 7) begin errors++; $display("FAIL start_spacing_2: got %0d expected 7", sg[2] - sg[1]); end
    end
    checks++; if (bus.gen_count !== 16'd3) begin errors++; $display("FAIL free_run_gen_count: got %0d expected 3", bus.gen_count); end
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL free_run_running: got %b expected 1", bus.running); end
  endtask

  task automatic test_stop_mid_gen();
    int found = 0;
    int extra = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (bus.start_gen) found = 1;
    end
    checks++; if (found == 0) begin errors++; $display("FAIL stop_wait_start: got none expected start_gen"); end
    tick();
    bus.stop = 1;
    tick();
    bus.stop = 0;
    repeat (2) tick();
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL stop_remembered_running: got %b expected 1", bus.running); end
    bus.gen_done = 1;
    tick();
    bus.gen_done = 0;
    checks++; if (bus.gen_count !== 16'd4) begin errors++; $display("FAIL stop_gen_count: got %0d expected 4", bus.gen_count); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.start_gen) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL stop_no_more_starts: got %0d expected 0", extra); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b expected 0", bus.running); end
  endtask

  task automatic test_step();
    int starts = 0;
    bus.gen_done = 1;
    tick();
    bus.gen_done = 0;
    tick();
    checks++; if (bus.gen_count !== 16'd4) begin errors++; $display("FAIL ready_gen_done_ignored: got %0d expected 4", bus.gen_count); end
    bus.step = 1;
    tick();
    bus.step = 0;
    checks++; if ({bus.start_gen, bus.busy, bus.running} !== 3'b110) begin
      errors++; $display("FAIL step_entry: got %b expected 110", {bus.start_gen, bus.busy, bus.running}); end
    tick();
    if (bus.start_gen) starts++;
    tick();
    if (bus.start_gen) starts++;
    bus.gen_done = 1;
    tick();
    bus.gen_done = 0;
    checks++; if (starts != 0) begin errors++; $display("FAIL step_single_pulse: got %0d extra expected 0", starts); end
    checks++; if (bus.gen_count !== 16'd5) begin errors++; $display("FAIL step_gen_count: got %0d expected 5", bus.gen_count); end
    checks++; if ({bus.busy, bus.running} !== 2'b00) begin errors++; $display("FAIL step_ready: got %b expected 00", {bus.busy, bus.running}); end
  endtask

  task automatic test_priority();
    int k = cyc;
    int found = 0;
    bus.load_val = 8'hAA;
    bus.go = 1; bus.step = 1; bus.set = 1;
    tick();
    bus.go = 0; bus.step = 0; bus.set = 0;
    checks++; if ({bus.running, bus.start_gen, bus.busy} !== 3'b100) begin
      errors++; $display("FAIL priority_state: got %b expected 100", {bus.running, bus.start_gen, bus.busy}); end
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      checks++; if (bus.x_out !== 8'h12) begin errors++; $display("FAIL priority_x_out: got %0h expected 12", bus.x_out); end
      if (bus.start_gen) begin found = 1; sg_cyc = cyc; end
    end
    checks++; if (found == 0 || sg_cyc - k != 5) begin
      errors++; $display("FAIL priority_start_delay: got %0d expected 5", sg_cyc - k); end
  endtask

  task automatic test_stop_at_tick();
    int starts = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.start_gen) starts++;
      if (cyc == sg_cyc + 6) begin
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL tick_last_running: got %b expected 1", bus.running); end
      end
      bus.gen_done = (cyc == sg_cyc + 2);
      bus.stop = (cyc == sg_cyc + 6);
    end
    bus.gen_done = 0; bus.stop = 0;
    checks++; if (starts != 0) begin errors++; $display("FAIL stop_beats_tick: got %0d starts expected 0", starts); end
    checks++; if (bus.gen_count !== 16'd6) begin errors++; $display("FAIL stop_tick_gen_count: got %0d expected 6", bus.gen_count); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL stop_tick_running: got %b expected 0", bus.running); end
  endtask

  task automatic test_reset_mid_gen();
    int found = 0;
    bus.go = 1;
    tick();
    bus.go = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (bus.start_gen) found = 1;
    end
    checks++; if (found == 0) begin errors++; $display("FAIL rst_wait_start: got none expected start_gen"); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if ({bus.draw_cell, bus.start_gen, bus.running, bus.busy} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {bus.draw_cell, bus.start_gen, bus.running, bus.busy}); end
    checks++; if (bus.gen_count !== 16'd0) begin errors++; $display("FAIL rst_mid_gen_count: got %0d expected 0", bus.gen_count); end
    checks++; if (bus.x_out !== 8'h00) begin errors++; $display("FAIL rst_mid_x_out: got %0h expected 0", bus.x_out); end
    bus.gen_done = 1;
    tick();
    bus.gen_done = 0;
    bus.step = 1;
    tick();
    bus.step = 0;
    checks++; if (bus.start_gen !== 1'b0) begin errors++; $display("FAIL idle_step_ignored: got %b expected 0", bus.start_gen); end
    tick();
    checks++; if (bus.gen_count !== 16'd0) begin errors++; $display("FAIL late_gen_done_ignored: got %0d expected 0", bus.gen_count); end
    checks++; if ({bus.busy, bus.running} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b expected 00", {bus.busy, bus.running}); end
  endtask

  initial begin
    test_reset();
    test_cell_entry();
    test_free_run();
    test_stop_mid_gen();
    test_step();
    test_priority();
    test_stop_at_tick();
    test_reset_mid_gen();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
